// File: rtl/fpu_ss_regfile_mp.sv
// Multi-port FP register file with NaN-boxing and a per-register write-back scoreboard.
// Latency: write visible next cycle; FPU_SS_RF_BYPASS_EN forwards same-cycle writes to reads.
// Backpressure: writes always accepted; reservations refused while the target is busy.
module fpu_ss_regfile_mp #(
    parameter int unsigned FLEN     = 32,
    parameter int unsigned NumWords = 32,
    parameter int unsigned NumRead  = 3,
    parameter int unsigned NumWrite = 2,
    parameter int unsigned AW       = $clog2(NumWords)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumRead-1:0][AW-1:0]         raddr_i,
    output logic [NumRead-1:0][FLEN-1:0]       rdata_o,
    output logic [NumRead-1:0]                 rbusy_o,
    input  logic [NumWrite-1:0]                we_i,
    input  logic [NumWrite-1:0][AW-1:0]        waddr_i,
    input  logic [NumWrite-1:0][FLEN-1:0]      wdata_i,
    input  logic [NumWrite-1:0]                wnarrow_i,
    input  logic                               rsv_valid_i,
    input  logic [AW-1:0]                      rsv_addr_i,
    output logic                               rsv_ready_o,
    input  logic                               flush_i
);

    logic [FLEN-1:0]                mem_q [NumWords];
    logic [NumWords-1:0]            busy_q;
    logic [NumWords-1:0]            busy_d;
    logic [NumWrite-1:0][FLEN-1:0]  wval;

    generate
        if (FLEN == 64) begin : g_nanbox
            always_comb begin
                for (int p = 0; p < NumWrite; p++) begin
                    wval[p] = wdata_i[p];
                    if (wnarrow_i[p]) begin
                        wval[p][FLEN-1:32] = '1;
                    end
                end
            end
        end else begin : g_no_nanbox
            // Single-precision file: narrow writes already fill the register.
            logic unused_narrow;
            assign unused_narrow = ^wnarrow_i;
            assign wval = wdata_i;
        end
    endgenerate

    assign rsv_ready_o = rsv_valid_i & ~busy_q[rsv_addr_i];

    // Reservation is applied last so a new producer outlives a write or flush in the same cycle.
    always_comb begin
        busy_d = flush_i ? '0 : busy_q;
        for (int p = 0; p < NumWrite; p++) begin
            if (we_i[p]) begin
                busy_d[waddr_i[p]] = 1'b0;
            end
        end
        if (rsv_ready_o) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            // Later ports overwrite earlier ones on an address collision.
            for (int p = 0; p < NumWrite; p++) begin
                if (we_i[p]) begin
                    mem_q[waddr_i[p]] <= wval[p];
                end
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NumRead; r++) begin
            rdata_o[r] = mem_q[raddr_i[r]];
            rbusy_o[r] = busy_q[raddr_i[r]];
`ifdef FPU_SS_RF_BYPASS_EN
            for (int p = 0; p < NumWrite; p++) begin
                if (we_i[p] && (waddr_i[p] == raddr_i[r])) begin
                    rdata_o[r] = wval[p];
                    rbusy_o[r] = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_fpu_ss_regfile_mp.sv
// Bench for fpu_ss_regfile_mp at FLEN=64: directed vector table, hand sequences, random vs reference model.
module tb_fpu_ss_regfile_mp;
    localparam int FLEN = 64;
    localparam int NW   = 32;
    localparam int NR   = 3;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [NR-1:0][AW-1:0]     raddr;
    logic [NR-1:0][FLEN-1:0]   rdata;
    logic [NR-1:0]             rbusy;
    logic [NWR-1:0]            we;
    logic [NWR-1:0][AW-1:0]    waddr;
    logic [NWR-1:0][FLEN-1:0]  wdata;
    logic [NWR-1:0]            wnarrow;
    logic                      rsv_valid;
    logic [AW-1:0]             rsv_addr;
    logic                      rsv_ready;
    logic                      flush;

    fpu_ss_regfile_mp #(.FLEN(FLEN), .NumWords(NW), .NumRead(NR), .NumWrite(NWR)) dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wnarrow_i(wnarrow),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready), .flush_i(flush)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [63:0] mem_m  [NW];
    logic        busy_m [NW];

    typedef struct {
        logic        we0; logic [4:0] wa0; logic [63:0] wd0; logic wn0;
        logic        we1; logic [4:0] wa1; logic [63:0] wd1; logic wn1;
        logic        rv;  logic [4:0] ra;  logic fl;
        logic [4:0]  rchk;
        logic        exp_rdy; logic [63:0] exp_d; logic exp_b;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] box(input logic [63:0] d, input logic n);
        return n ? {32'hFFFF_FFFF, d[31:0]} : d;
    endfunction

    function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [63:0] wd0, input logic wn0,
                                input logic we1, input logic [4:0] wa1, input logic [63:0] wd1, input logic wn1,
                                input logic rv, input logic [4:0] ra, input logic fl, input logic [4:0] rchk,
                                input logic er, input logic [63:0] ed, input logic eb);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0; v.wn0 = wn0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1; v.wn1 = wn1;
        v.rv = rv; v.ra = ra; v.fl = fl; v.rchk = rchk;
        v.exp_rdy = er; v.exp_d = ed; v.exp_b = eb;
        return v;
    endfunction

    task automatic idle();
        rst = 1'b0; we = '0; waddr = '0; wdata = '0; wnarrow = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            mem_m[i] = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    // One vector: drive one cycle, check ready before the edge, then read back the checked register.
    task automatic apply(input int idx, input vec_t v);
        we = {v.we1, v.we0}; waddr = {v.wa1, v.wa0}; wdata = {v.wd1, v.wd0}; wnarrow = {v.wn1, v.wn0};
        rsv_valid = v.rv; rsv_addr = v.ra; flush = v.fl;
        #3;
        check($sformatf("vec%0d_rdy", idx), 64'(rsv_ready), 64'(v.exp_rdy));
        @(posedge clk); #1;
        idle();
        raddr[0] = v.rchk;
        #1;
        check($sformatf("vec%0d_data", idx), rdata[0], v.exp_d);
        check($sformatf("vec%0d_busy", idx), 64'(rbusy[0]), 64'(v.exp_b));
    endtask

    initial begin
        logic [63:0] ed;
        logic        eb;
        logic        acc;

        idle();
        raddr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int r = 0; r < NR; r++) begin
            check($sformatf("post_reset_data%0d", r), rdata[r], 64'h0);
            check($sformatf("post_reset_busy%0d", r), 64'(rbusy[r]), 64'h0);
        end

        // Reset overrides pending writes, reservations and flush, and drops busy bits.
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 64'h3F80_0000;
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        @(posedge clk); #1;
        idle();
        raddr[0] = 5'd5; raddr[1] = 5'd6;
        #1;
        check("preload_f5", rdata[0], 64'h3F80_0000);
        check("preload_f6_busy", 64'(rbusy[1]), 64'h1);
        rst = 1'b1; we[0] = 1'b1; waddr[0] = 5'd8; wdata[0] = 64'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd1; flush = 1'b1;
        @(posedge clk); #1;
        idle();
        raddr = {5'd8, 5'd6, 5'd5};
        #1;
        for (int r = 0; r < NR; r++) begin
            check($sformatf("reset_data%0d", r), rdata[r], 64'h0);
            check($sformatf("reset_busy%0d", r), 64'(rbusy[r]), 64'h0);
        end
        rsv_valid = 1'b1; rsv_addr = 5'd1;
        #1;
        check("reset_rsv_f1_ready", 64'(rsv_ready), 64'h1);
        idle();

        vecs[0]  = mk(1,  3, 64'h0000_0000_4049_0FDB, 1, 0, 0, 64'h0, 0, 0, 0, 0,  3, 0, 64'hFFFF_FFFF_4049_0FDB, 0);
        vecs[1]  = mk(1,  3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 64'h0, 0, 0, 0, 0,  3, 0, 64'h0123_4567_89AB_CDEF, 0);
        vecs[2]  = mk(0,  0, 64'h0, 0, 1,  3, 64'h1234_5678_AAAA_5555, 1, 0, 0, 0,  3, 0, 64'hFFFF_FFFF_AAAA_5555, 0);
        vecs[3]  = mk(1,  7, 64'h1111_1111, 0, 1,  7, 64'h2222_2222, 0, 0, 0, 0,  7, 0, 64'h2222_2222, 0);
        vecs[4]  = mk(0,  0, 64'h0, 0, 0,  0, 64'h0, 0, 1,  9, 0,  9, 1, 64'h0, 1);
        vecs[5]  = mk(0,  0, 64'h0, 0, 0,  0, 64'h0, 0, 1,  9, 0,  9, 0, 64'h0, 1);
        vecs[6]  = mk(0,  0, 64'h0, 0, 1,  9, 64'h5, 0, 0, 0, 0,  9, 0, 64'h5, 0);
        vecs[7]  = mk(1,  9, 64'h77, 0, 0,  0, 64'h0, 0, 1,  9, 0,  9, 1, 64'h77, 1);
        vecs[8]  = mk(0,  0, 64'h0, 0, 0,  0, 64'h0, 0, 0,  0, 1,  9, 0, 64'h77, 0);
        vecs[9]  = mk(0,  0, 64'h0, 0, 0,  0, 64'h0, 0, 1, 10, 0, 10, 1, 64'h0, 1);
        vecs[10] = mk(0,  0, 64'h0, 0, 0,  0, 64'h0, 0, 1, 11, 1, 11, 1, 64'h0, 1);
        vecs[11] = mk(0,  0, 64'h0, 0, 0,  0, 64'h0, 0, 0,  0, 0, 10, 0, 64'h0, 0);
        vecs[12] = mk(1, 11, 64'h99, 0, 0,  0, 64'h0, 0, 1, 11, 0, 11, 0, 64'h99, 0);
        vecs[13] = mk(0,  0, 64'h0, 0, 1, 12, 64'hC0FFEE, 0, 0, 0, 1, 12, 0, 64'hC0FFEE, 0);
        vecs[14] = mk(1, 13, 64'hFEDC_BA98_7654_3210, 0, 1, 13, 64'h1, 1, 0, 0, 0, 13, 0, 64'hFFFF_FFFF_0000_0001, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) apply(i, vecs[i]);

        // Same-cycle write and read of a busy register.
        @(posedge clk); #1;
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        @(posedge clk); #1;
        idle();
        we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 64'hDEAD_BEEF; raddr[1] = 5'd4;
        #3;
`ifdef FPU_SS_RF_BYPASS_EN
        check("bypass_same_data", rdata[1], 64'hDEAD_BEEF);
        check("bypass_same_busy", 64'(rbusy[1]), 64'h0);
`else
        check("nobypass_same_data", rdata[1], 64'h0);
        check("nobypass_same_busy", 64'(rbusy[1]), 64'h1);
`endif
        @(posedge clk); #1;
        idle();
        #1;
        check("write_next_data", rdata[1], 64'hDEAD_BEEF);
        check("write_next_busy", 64'(rbusy[1]), 64'h0);

        // Randomized phase against the reference model, starting from a clean reset.
        rst = 1'b1;
        @(posedge clk); #1;
        idle();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < NWR; p++) begin
                we[p]      = ($urandom_range(0, 2) == 0);
                waddr[p]   = 5'($urandom_range(0, 7));
                wdata[p]   = {$urandom, $urandom};
                wnarrow[p] = $urandom_range(0, 1) == 1;
            end
            for (int r = 0; r < NR; r++) raddr[r] = 5'($urandom_range(0, 7));
            rsv_valid = $urandom_range(0, 1) == 1;
            rsv_addr  = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            #3;
            acc = rsv_valid && !busy_m[rsv_addr];
            check($sformatf("rnd%0d_rdy", c), 64'(rsv_ready), 64'(acc));
            for (int r = 0; r < NR; r++) begin
                ed = mem_m[raddr[r]];
                eb = busy_m[raddr[r]];
`ifdef FPU_SS_RF_BYPASS_EN
                for (int p = 0; p < NWR; p++) begin
                    if (we[p] && waddr[p] == raddr[r]) begin
                        ed = box(wdata[p], wnarrow[p]);
                        eb = 1'b0;
                    end
                end
`endif
                check($sformatf("rnd%0d_data%0d", c, r), rdata[r], ed);
                check($sformatf("rnd%0d_busy%0d", c, r), 64'(rbusy[r]), 64'(eb));
            end
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                if (flush) for (int i = 0; i < NW; i++) busy_m[i] = 1'b0;
                for (int p = 0; p < NWR; p++) begin
                    if (we[p]) begin
                        mem_m[waddr[p]]  = box(wdata[p], wnarrow[p]);
                        busy_m[waddr[p]] = 1'b0;
                    end
                end
                if (acc) busy_m[rsv_addr] = 1'b1;
            end
            #1;
        end
        idle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/fpu_ss_regfile_mp.md
# fpu_ss_regfile_mp

Parametrised multi-port floating-point register file with an integrated write-back scoreboard for the FPU subsystem. It replaces the fixed 32×32-bit, 3-read/1-write file. It adds a configurable data width (FLEN), read/write port counts, NaN-boxing of narrow writes, and per-register busy tracking so the issue stage can stall on outstanding results. It sits between the FPU subsystem decoder/issue logic and the FPnew write-back and load/store return paths.

## Interface
Parameters:
- `FLEN`, 32, register width in bits; must be 32 or 64.
- `NumWords`, 32, number of registers; power of two, ≥2.
- `NumRead`, 3, number of read ports.
- `NumWrite`, 2, number of write ports.
- `AW`, $clog2(NumWords), address width (derived; do not override).

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `raddr_i`  in  [NumRead][AW]  read addresses.
- `rdata_o`  out  [NumRead][FLEN]  read data.
- `rbusy_o`  out  [NumRead]  addressed register has a pending write.
- `we_i`  in  [NumWrite]  write enable per port.
- `waddr_i`  in  [NumWrite][AW]  write address per port.
- `wdata_i`  in  [NumWrite][FLEN]  write data per port.
- `wnarrow_i`  in  [NumWrite]  write is single-precision; NaN-box it.
- `rsv_valid_i`  in  1  reserve (mark busy) request.
- `rsv_addr_i`  in  [AW]  register to reserve.
- `rsv_ready_o`  out  1  reservation accepted this cycle.
- `flush_i`  in  1  clear all busy bits.

## Operation
- Storage: NumWords × FLEN flops plus NumWords busy bits. All registers are writable; there is no hard-wired zero register.
- Write: on a rising edge with `we_i[p]`, `mem[waddr_i[p]]` takes the port's value.
  - If `wnarrow_i[p]` and FLEN=64, the stored value is {32'hFFFF_FFFF, wdata_i[p][31:0]}.
  - If FLEN=32, `wnarrow_i` is ignored.
- Write collision: several ports writing the same address in one cycle → the highest-indexed port wins. No error is flagged.
- Scoreboard:
  - `rsv_ready_o` = `rsv_valid_i` & ~busy[rsv_addr_i].
  - An accepted reservation sets busy[rsv_addr_i] at the next edge.
  - Any write to address a clears busy[a] at the next edge.
- Simultaneous events at the same edge:
  - Reservation and write to the same address → busy ends at 1. The new producer wins.
  - `flush_i` and an accepted reservation → busy ends at 1 for the reserved address; all others clear.
  - `flush_i` never blocks data writes.
- `rsv_ready_o` uses the registered busy bit only. A reservation of a register being written this same cycle while busy is refused; the requester retries next cycle.
- Read: `rdata_o[r]` = mem[raddr_i[r]]; `rbusy_o[r]` = busy[raddr_i[r]]. Both are combinational from registered state (bypass behaviour is described under Configuration).

## Timing
- Reset: while `rst_i` is high at an edge, all mem words → 0 and all busy → 0. Reset overrides writes, reservations and flush in that cycle. Reset asserted mid-operation discards outstanding reservations.
- Reset-state outputs: `rdata_o` = 0, `rbusy_o` = 0, `rsv_ready_o` = `rsv_valid_i`.
- Write-to-read latency: 1 cycle without bypass; 0 cycles with bypass.
- Reservation-to-busy latency: 1 cycle. Write-to-busy-clear latency: 1 cycle (0 with bypass as seen on `rbusy_o`).
- No handshake back-pressure on write ports: writes are always accepted.

## Configuration
- `FPU_SS_RF_BYPASS_EN` defined:
  - Each read port compares `raddr_i[r]` against all active write ports in the same cycle. On a match, `rdata_o[r]` returns the NaN-boxed write data of the highest-indexed matching port, and `rbusy_o[r]` = 0.
  - The paths from `wdata_i` to `rdata_o` and from `we_i` to `rbusy_o` become combinational.
  - `rsv_ready_o` is unaffected.
- `FPU_SS_RF_BYPASS_EN` undefined: reads see registered state only; a same-cycle write is invisible until the next cycle.

## Test plan
- Reset: preload f5 = 0x3F80_0000, assert `rst_i` one cycle → all read ports return 0, `rbusy_o` = 0.
- NaN-boxing (FLEN=64): write port 0 to f3 with `wnarrow_i`=1 and data 0x0000_0000_4049_0FDB → next cycle f3 reads 0xFFFF_FFFF_4049_0FDB.
- Collision: ports 0 and 1 both write f7, with 0x1111_1111 and 0x2222_2222 → f7 reads 0x2222_2222.
- Scoreboard:
  - Reserve f9 → `rsv_ready_o`=1, and next cycle `rbusy_o`=1 on a port reading f9.
  - A second reserve of f9 → `rsv_ready_o`=0.
  - Write f9 → busy clears the following cycle.
- Simultaneous reserve and write to f9 while f9 is idle → f9 data updated and busy=1. Then `flush_i` → busy=0 next cycle with data retained.
- Bypass:
  - Macro defined: a cycle writing f4=0xDEAD_BEEF while reading f4 → same-cycle `rdata_o`=0xDEAD_BEEF and `rbusy_o`=0.
  - Macro undefined: same cycle returns the old value; the new value appears one cycle later.
